// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the tiny ALU: queues commands in a FIFO, drives the ALU
// start/done handshake with a timeout, and returns tagged results in order.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [DATA_W-1:0]          cmd_a,
  input  logic [DATA_W-1:0]          cmd_b,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic                       alu_start,
  output logic [2:0]                 alu_op,
  output logic [DATA_W-1:0]          alu_a,
  output logic [DATA_W-1:0]          alu_b,
  input  logic                       alu_done,
  input  logic [2*DATA_W-1:0]        alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [2*DATA_W-1:0]        rsp_result,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH):0]     cmd_count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [TAG_W-1:0]  tag;
  } cmd_t;

  cmd_t           mem [DEPTH];
  cmd_t           head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;

  state_t         state;
  logic [TW-1:0]  tcnt;
  logic [TW-1:0]  tcnt_next;
  logic [TAG_W-1:0] hold_tag;

  assign cmd_ready = (count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // Launch only with no response outstanding, which keeps responses in order.
  assign pop       = (state == IDLE) && (count != '0) && !rsp_valid;
  assign head      = mem[rd_ptr];
  assign cmd_count = count;
  assign busy      = (state != IDLE) || (count != '0);
  assign tcnt_next = tcnt + 1'b1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, tag: cmd_tag};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      hold_tag   <= '0;
      alu_start  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            alu_op    <= head.op;
            alu_a     <= head.a;
            alu_b     <= head.b;
            hold_tag  <= head.tag;
            alu_start <= 1'b1;
            tcnt      <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt <= tcnt_next;
          // done takes priority over a timeout expiring in the same cycle
          if (alu_done) begin
            rsp_result <= (alu_op == 3'd0) ? '0 : alu_result;
            rsp_tag    <= hold_tag;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= GAP;
          end else if (tcnt_next == TW'(TIMEOUT)) begin
            rsp_result <= '0;
            rsp_tag    <= hold_tag;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            alu_start  <= 1'b0;
            state      <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
